// File: rtl/freq_meter_ctrl.sv
// freq_meter_ctrl: gated frequency measurement sequencer with manual or auto range selection
module freq_meter_ctrl #(
  parameter int GATE0_CYCLES = 100_000_000,
  parameter int GATE1_CYCLES = 10_000_000,
  parameter int GATE2_CYCLES = 1_000_000,
  parameter int GAP_CYCLES   = 16,
  parameter int COUNT_MAX    = 9999,
  parameter int DOWN_THRESH  = 900
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Fxin,
  input  logic        Enable,
  input  logic        Auto_Range,
  input  logic [1:0]  Range_Sel,
  output logic [13:0] Frequency_Bin,
  output logic [1:0]  Range,
  output logic        Overflow,
  output logic        Valid,
  output logic        Gate_Signal,
  output logic        Busy
);
  localparam int TW = $clog2(GATE0_CYCLES + 1);
  localparam logic [13:0] CMAX = 14'(COUNT_MAX);
  localparam logic [13:0] DTH = 14'(DOWN_THRESH);
  localparam logic [TW-1:0] GAPL = TW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, GATE, LATCH, GAP} state_t;
  state_t state;
  logic [2:0] sync;
  logic [TW-1:0] timer, load_len;
  logic [13:0] count;
  logic [1:0] cur_range, next_range, sel, auto_range_nxt;
  logic fx_rise, ovf;
  always_comb begin
    sel = Range_Sel == 2'd3 ? 2'd2 : Range_Sel;
    next_range = Auto_Range ? cur_range : sel;
    load_len = next_range == 2'd0 ? TW'(GATE0_CYCLES - 1) :
               next_range == 2'd1 ? TW'(GATE1_CYCLES - 1) : TW'(GATE2_CYCLES - 1);
    fx_rise = sync[1] & ~sync[2];
    ovf = count > CMAX;
    auto_range_nxt = (ovf && cur_range != 2'd2) ? cur_range + 2'd1 :
                     (count < DTH && cur_range != 2'd0) ? cur_range - 2'd1 : cur_range;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      sync <= '0;
      timer <= '0;
      count <= '0;
      cur_range <= '0;
      Frequency_Bin <= '0;
      Range <= '0;
      Overflow <= 1'b0;
      Valid <= 1'b0;
      Gate_Signal <= 1'b0;
      Busy <= 1'b0;
    end else begin
      sync <= {sync[1:0], Fxin};
      Valid <= 1'b0;
      case (state)
        IDLE: if (Enable) begin
          state <= GATE;
          cur_range <= next_range;
          timer <= load_len;
          count <= '0;
          Gate_Signal <= 1'b1;
          Busy <= 1'b1;
        end
        GATE: if (!Enable) begin
          state <= IDLE;
          count <= '0;
          Gate_Signal <= 1'b0;
          Busy <= 1'b0;
        end else begin
          if (fx_rise && count <= CMAX) count <= count + 14'd1;
          if (timer == '0) begin
            state <= LATCH;
            Gate_Signal <= 1'b0;
          end else timer <= timer - 1'b1;
        end
        LATCH: begin
          Frequency_Bin <= ovf ? CMAX : count;
          Overflow <= ovf;
          Range <= cur_range;
          Valid <= 1'b1;
          if (Auto_Range) cur_range <= auto_range_nxt;
          timer <= GAPL;
          state <= GAP;
        end
        GAP: if (!Enable) begin
          state <= IDLE;
          Busy <= 1'b0;
        end else if (timer == '0) begin
          state <= GATE;
          cur_range <= next_range;
          timer <= load_len;
          count <= '0;
          Gate_Signal <= 1'b1;
        end else timer <= timer - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/freq_meter_ctrl.md
# freq_meter_ctrl

Measurement sequencer for the frequency meter. It replaces the free-running gate generator and the gate-qualified ripple counter with one fully synchronous controller. It synchronises the unknown input Fxin into the Clk domain, runs timed gate windows, counts Fxin rising edges, and publishes a saturated 14-bit result with a valid pulse. It also selects the gate length per measurement, either by manual setting or by auto-ranging. Downstream, Frequency_Bin feeds the binary-to-BCD converter, and Range drives the display decimal point.

## Interface
- GATE0_CYCLES, 100_000_000, gate length for range 0 (longest gate, finest resolution)
- GATE1_CYCLES, 10_000_000, gate length for range 1
- GATE2_CYCLES, 1_000_000, gate length for range 2
- GAP_CYCLES, 16, idle cycles between consecutive gates (minimum 1)
- COUNT_MAX, 9999, largest reportable count (4-digit display)
- DOWN_THRESH, 900, auto-range step-down threshold
- Clk  in  1  system clock, the single clock of the block
- Rst  in  1  asynchronous, active-high reset
- Fxin  in  1  unknown input, asynchronous to Clk, frequency < Clk/2
- Enable  in  1  run continuous measurements while high
- Auto_Range  in  1  1 = automatic range selection, 0 = use Range_Sel
- Range_Sel  in  2  manual range 0..2; value 3 is treated as 2
- Frequency_Bin  out  14  last published count, saturated at COUNT_MAX
- Range  out  2  range that produced Frequency_Bin
- Overflow  out  1  last count exceeded COUNT_MAX
- Valid  out  1  one-cycle pulse when a new result is published
- Gate_Signal  out  1  high during the counting window
- Busy  out  1  high whenever state is not IDLE

## Operation
- Input path: Fxin passes through a 2-flop synchroniser and then an edge register. A rising edge is detected as sync2 & ~sync3.
- Edge counter: 14 bits. It counts only detected edges that fall in GATE state, and it saturates at COUNT_MAX+1. It clears on entry to GATE.
- Gate timer: wide enough for GATE0_CYCLES. It loads the length for the active range (cur_range) on entry to GATE.
- States:
  - IDLE: wait for Enable=1, then go to GATE. On the same transition, cur_range takes Range_Sel when Auto_Range=0; in auto mode cur_range keeps its value.
  - GATE: Gate_Signal=1 for exactly Gn cycles, then go to LATCH. If Enable drops, go to IDLE: no Valid, outputs held, counter cleared.
  - LATCH: one cycle. Update the outputs as follows, then go to GAP.
    - Frequency_Bin = min(count, COUNT_MAX).
    - Overflow = (count > COUNT_MAX).
    - Range = cur_range.
    - Valid = 1.
  - GAP: GAP_CYCLES cycles. If Enable drops, go to IDLE. At the end, go to GATE, reloading cur_range from Range_Sel in manual mode.
- Auto-range decision, made in LATCH and applied to the next gate:
  - Overflow and cur_range<2: cur_range+1.
  - count<DOWN_THRESH and cur_range>0: cur_range-1.
  - Otherwise cur_range is unchanged.
  - Overflow at range 2 is reported and the range stays at 2.
- Mode change: a switch of Auto_Range mid-gate takes effect at the next gate start. The running gate completes at its original length.

## Timing
- Reset values: Frequency_Bin=0, Range=0, Overflow=0, Valid=0, Gate_Signal=0, Busy=0, cur_range=0, state IDLE, counters 0.
- Start: Enable sampled high at edge k puts the block in GATE from edge k+1. Gate_Signal and Busy are registered and high from that cycle.
- Gate window: Gate_Signal is high for exactly Gn consecutive cycles. LATCH is the next cycle, and Valid plus the new outputs appear registered one cycle after LATCH. Outputs hold until the next Valid.
- Measurement period: Gn + 1 + GAP_CYCLES cycles.
- Detection latency: an Fxin edge is counted when it is detected inside the window. The 3-cycle synchroniser delay shifts the effective window by 3 cycles. An edge detected in the LATCH cycle is dropped.
- Abort: Enable low at any edge in GATE or GAP gives IDLE on the next cycle, Gate_Signal=0 and Busy=0. The last published results are held.
- Rst mid-gate: everything returns to reset values immediately. No Valid is produced.

## Test plan
- Config for all tests: GATE0=100000, GATE1=10000, GATE2=1000, GAP=16.
- Manual range 1, Fxin period 40 clk, 3 gates → Valid every 10017 cycles, Frequency_Bin=250, Range=1, Overflow=0.
- Auto, start range 0, Fxin period 4 clk → first result 9999 with Overflow=1 and Range=0; next 2500, Range=1, Overflow=0; stays at range 1.
- Auto at range 1, switch Fxin to period 400 (count 25<900) → next gate runs at range 0 and gives 250. Range 2 with Fxin period 4 → 250 <900 → range 1 → 2500.
- Manual range 2, Fxin period 2 (Clk/2 minus margin: use period 3) → 333 or 334, Overflow=0. Range_Sel=3 behaves as 2.
- Enable dropped at cycle 500 of a range-2 gate → Gate_Signal low next cycle, no Valid, Frequency_Bin unchanged. Re-enable → full 1000-cycle gate and correct count.
- Rst pulsed mid-gate → all outputs zero asynchronously. After release with Enable high, the first gate starts at range 0.
